// File: rtl/uint_arith_pkg.sv
// Shared types for the UInt limb arithmetic streams.
// Limb width default, limb type and the limb-walk state.
package uint_arith_pkg;

  localparam int DEF_LIMB_WIDTH = 3;

  typedef logic [DEF_LIMB_WIDTH-1:0] limb_t;

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_t;

endpackage

// File: rtl/limb_sbc.sv
// Combinational one-limb subtract-with-borrow.
// d = a - b - bin modulo 2**W, bout set on underflow.
module limb_sbc #(
  parameter int W = uint_arith_pkg::DEF_LIMB_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] diff;

  // Extended-width subtract; the top bit is the borrow.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  end

  assign d    = diff[W-1:0];
  assign bout = diff[W];

endmodule

// File: rtl/uint_limb_sbc_stream.sv
// Streaming multi-limb unsigned subtract-with-borrow.
// Limbs arrive LSB first; borrow is chained in a register.
module uint_limb_sbc_stream
  import uint_arith_pkg::*;
#(
  parameter int LIMB_WIDTH = DEF_LIMB_WIDTH,
  parameter int MAX_LIMBS  = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LIMB_WIDTH-1:0] I0,
  input  logic [LIMB_WIDTH-1:0] I1,
  input  logic                  BIN,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LIMB_WIDTH-1:0] O,
  output logic                  out_last,
  output logic                  BOUT,
  output logic [IDX_WIDTH-1:0]  limb_idx,
  output logic                  TRUNC
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(MAX_LIMBS - 1);

  state_t                 state;
  logic                   borrow;
  logic [IDX_WIDTH-1:0]   count;
  logic                   accept;
  logic                   borrow_in;
  logic                   last_eff;
  logic [LIMB_WIDTH-1:0]  d;
  logic                   bo;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_eff = in_last || (count == LAST_IDX);

  // First limb takes the external borrow, later limbs the chain.
  always_comb begin
    borrow_in = borrow;
    if (state == FIRST) borrow_in = BIN;
  end

  limb_sbc #(
    .W(LIMB_WIDTH)
  ) u_sbc (
    .a   (I0),
    .b   (I1),
    .bin (borrow_in),
    .d   (d),
    .bout(bo)
  );

  // Output register, borrow chain, limb counter and state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      BOUT      <= 1'b0;
      TRUNC     <= 1'b0;
      O         <= '0;
      limb_idx  <= '0;
      borrow    <= 1'b0;
      count     <= '0;
      state     <= FIRST;
    end else if (accept) begin
      out_valid <= 1'b1;
      O         <= d;
      out_last  <= last_eff;
      TRUNC     <= last_eff && !in_last;
      BOUT      <= last_eff && bo;
      limb_idx  <= count;
      count     <= last_eff ? '0 : count + 1'b1;
      borrow    <= last_eff ? 1'b0 : bo;
      state     <= last_eff ? FIRST : MID;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/uint_limb_sbc_stream.md
Name: uint_limb_sbc_stream

Overview:
- Streaming multi-limb unsigned subtract-with-borrow engine; the inverse of the datapath's add-with-carry adder.
- Accepts wide operands as a stream of LIMB_WIDTH-bit limbs, least significant first, over a valid/ready handshake.
- Produces difference limbs plus a final borrow-out, and carries the borrow between limbs in a register.
- Sits downstream of operand serializers in the UInt arithmetic pipeline; one output register stage.

Parameters:
- LIMB_WIDTH, 3, bits per limb.
- MAX_LIMBS, 8, maximum limbs per operand; a longer operand is truncated.
- IDX_WIDTH, 3, width of the limb index; must satisfy 2**IDX_WIDTH >= MAX_LIMBS.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  input limb valid.
- in_ready  output  1  input limb accepted when in_valid && in_ready.
- I0  input  LIMB_WIDTH  minuend limb.
- I1  input  LIMB_WIDTH  subtrahend limb.
- BIN  input  1  initial borrow-in; sampled only on the first limb of an operand.
- in_last  input  1  marks the most significant limb.
- out_valid  output  1  output limb valid.
- out_ready  input  1  downstream accept.
- O  output  LIMB_WIDTH  difference limb.
- out_last  output  1  final limb of the result.
- BOUT  output  1  final borrow-out; meaningful only when out_last=1, otherwise 0.
- limb_idx  output  IDX_WIDTH  index of the limb currently on O.
- TRUNC  output  1  with out_last, operand was cut at MAX_LIMBS.

Behaviour:
- Reset (synchronous, active-high, on CLK):
  - out_valid, out_last, BOUT, TRUNC = 0; O = 0; limb_idx = 0.
  - Internal borrow = 0, count = 0, state = FIRST.
  - RESET overrides any simultaneous handshake.
  - Reset mid-operand discards the partial result; the next accepted limb is treated as a first limb.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept fires when in_valid && in_ready.
  - Output held stable while out_valid && !out_ready.
  - Latency: 1 cycle from accept to out_valid.
  - Full throughput: one limb per cycle when out_ready stays high.
- State machine, two states:
  - FIRST: the accepted limb uses borrow_in = BIN.
  - MID: the accepted limb uses borrow_in = internal borrow register.
  - FIRST -> MID on accept with !last_eff.
  - MID -> FIRST on accept with last_eff.
  - Otherwise the state holds.
- Arithmetic, on accept:
  - diff[LIMB_WIDTH:0] = {1'b0,I0} - {1'b0,I1} - borrow_in, computed modulo 2**(LIMB_WIDTH+1).
  - O <= diff[LIMB_WIDTH-1:0].
  - borrow <= diff[LIMB_WIDTH], i.e. 1 iff I0 < I1 + borrow_in.
- last_eff = in_last || (count == MAX_LIMBS-1).
  - out_last <= last_eff.
  - TRUNC <= last_eff && !in_last.
  - BOUT <= last_eff ? diff[LIMB_WIDTH] : 0.
  - limb_idx <= count.
  - count <= last_eff ? 0 : count+1.
  - On last_eff the borrow register clears.
- Boundary cases:
  - Single-limb operand: in_last on the first limb; BIN is used and BOUT is produced.
  - A limb accepted in the same cycle the prior output is consumed is legal; the register is reloaded without a bubble.
  - out_valid drops to 0 when the output is consumed and no new accept occurs.
  - Worst-case limb 0 - 7 - 1 wraps: O = 0 with borrow 1.

Decomposition:
- Shared package uint_arith_pkg:
  - LIMB_WIDTH default.
  - State enum {FIRST, MID}.
  - Limb typedef logic [LIMB_WIDTH-1:0].
- One sub-module: limb_sbc, a combinational LIMB_WIDTH-bit subtract-with-borrow.
  - Inputs a, b, bin; outputs d, bout.
  - Reusable by other arithmetic streams.
- Handshake, state and counter logic stay in the top module.

Test Plan:
- Single limb, I0=5, I1=3, BIN=0, in_last=1 -> next cycle O=2, out_last=1, BOUT=0, limb_idx=0, TRUNC=0.
- Single limb, I0=2, I1=3, BIN=0, in_last=1 -> O=7, BOUT=1; repeat with I0=3, I1=3, BIN=1 -> O=7, BOUT=1.
- Three-limb 64-1, limbs LSB first: I0 = 0,0,1 and I1 = 1,0,0, BIN=0, last on limb 2 -> O = 7,7,0, limb_idx = 0,1,2, BOUT=0 on the final limb.
- Backpressure: out_ready=0 for 3 cycles during the multi-limb case -> O/out_valid held; in_ready=0; no limb lost; result identical to the no-stall case.
- Truncation: 8 limbs of I0=0, I1=0, BIN=1, in_last never set -> outputs O=7 for all 8 limbs, the 8th has out_last=1, TRUNC=1, BOUT=1; the next limb restarts with state FIRST.
- Reset after limb 1 of a 3-limb operand -> out_valid=0; a following single limb I0=4, I1=1, BIN=0, in_last=1 yields O=3, BOUT=0 (no stale borrow).
